// File: rtl/decode_seq_if.sv
// Decode-stage port bundle: F/D inputs, write-back and SP load going in, decoded controls,
// fetch steering and FSM debug coming out.
interface decode_seq_if #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int SPW  = 32
);
  localparam int AW = $clog2(NREG);

  logic [5:0]     opcode;
  logic [AW-1:0]  src;
  logic [AW-1:0]  dst;
  logic           irq;
  logic           stall_in;
  logic           flush_in;
  logic           wb_en;
  logic [AW-1:0]  wb_addr;
  logic [W-1:0]   wb_data;
  logic           sp_we;
  logic [SPW-1:0] sp_wdata;

  logic [W-1:0]   rsrc;
  logic [W-1:0]   rdst;
  logic [SPW-1:0] sp;
  logic [13:0]    ex_ctl;
  logic [6:0]     mem_ctl;
  logic [5:0]     wb_ctl;
  // Hold handshake: fd_en/pc_en low means fetch must keep F/D and PC unchanged
  // this cycle; high means fetch may advance, steered by jump_sel.
  logic           fd_en;
  logic           pc_en;
  logic [1:0]     jump_sel;
  logic           flush_out;
  logic           busy;

  logic [2:0]     dbg_state;
  logic [1:0]     dbg_step;
  logic           dbg_irq_pend;

  modport master (
    output opcode, src, dst, irq, stall_in, flush_in, wb_en, wb_addr, wb_data, sp_we, sp_wdata,
    input  rsrc, rdst, sp, ex_ctl, mem_ctl, wb_ctl, fd_en, pc_en, jump_sel, flush_out, busy,
    input  dbg_state, dbg_step, dbg_irq_pend
  );

  modport slave (
    input  opcode, src, dst, irq, stall_in, flush_in, wb_en, wb_addr, wb_data, sp_we, sp_wdata,
    output rsrc, rdst, sp, ex_ctl, mem_ctl, wb_ctl, fd_en, pc_en, jump_sel, flush_out, busy,
    output dbg_state, dbg_step, dbg_irq_pend
  );
endinterface

// File: rtl/decode_seq_stage.sv
// Decode stage: register file, SP, static control decode and the CALL/RET/RETI/interrupt
// stack sequencer. Define DECODE_RF_BYPASS_EN to forward same-cycle write-back to reads.
module decode_seq_stage #(
  parameter int             W        = 16,
  parameter int             NREG     = 8,
  parameter int             SPW      = 32,
  parameter logic [SPW-1:0] SP_INIT  = SPW'(32'h0000_0FFE),
  parameter int             PC_WORDS = 2
) (
  input logic         clk,
  input logic         rst,
  decode_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_INT, S_CALL, S_RET, S_RETI} state_e;

  localparam logic [5:0] OP_CALL = 6'h30;
  localparam logic [5:0] OP_RET  = 6'h31;
  localparam logic [5:0] OP_RETI = 6'h32;
  // mem_ctl: [0] write, [1] read, [2] sp_dec, [3] sp_inc, [4] flags word
  localparam logic [6:0] MC_PUSH = 7'h05;
  localparam logic [6:0] MC_POP  = 7'h0A;
  localparam logic [6:0] MC_FLAG = 7'h10;

  state_e         state_q, state_d;
  logic [1:0]     step_q, step_d;
  logic           irq_pend_q, irq_pend_d;
  logic [W-1:0]   rf_q [NREG];
  logic [SPW-1:0] sp_q;

  logic [13:0] dec_ex;
  logic [6:0]  dec_mem;
  logic [5:0]  dec_wb;
  logic [6:0]  seq_mem;
  logic [1:0]  last_idx;
  logic        flag_step;
  logic        bubble;
  logic        fd_en, pc_en, flush_out;
  logic [1:0]  jump_sel;

  // Static decode; ex_ctl[0] add, [1] sub, [8] address pass, [13] jump;
  // wb_ctl[0] reg write, [1] mem-to-reg.
  always_comb begin
    dec_ex  = '0;
    dec_mem = '0;
    dec_wb  = '0;
    case (bus.opcode)
      6'h01: begin dec_ex = 14'h0001; dec_wb = 6'h01; end
      6'h02: begin dec_ex = 14'h0002; dec_wb = 6'h01; end
      6'h03: begin dec_ex = 14'h0100; dec_mem = 7'h02; dec_wb = 6'h03; end
      6'h04: begin dec_ex = 14'h0100; dec_mem = 7'h01; end
      6'h05: dec_mem = 7'h05;
      6'h06: begin dec_mem = 7'h0A; dec_wb = 6'h03; end
      6'h07: dec_ex = 14'h2000;
      default: ;
    endcase
  end

  always_comb begin
    last_idx  = 2'(PC_WORDS - 1);
    flag_step = 1'b0;
    case (state_q)
      S_INT:  begin last_idx = 2'(PC_WORDS); flag_step = (step_q == 2'(PC_WORDS)); end
      S_RETI: begin last_idx = 2'(PC_WORDS); flag_step = (step_q == 2'd0); end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    irq_pend_d = irq_pend_q | bus.irq;
    bubble     = 1'b0;
    seq_mem    = '0;
    fd_en      = 1'b1;
    pc_en      = 1'b1;
    jump_sel   = 2'b00;
    flush_out  = 1'b0;
    if (bus.flush_in) begin
      bubble    = 1'b1;
      flush_out = 1'b1;
      state_d   = S_IDLE;
      step_d    = '0;
    end else if (state_q == S_IDLE) begin
      if (bus.irq || irq_pend_q) begin
        bubble     = 1'b1;
        fd_en      = 1'b0;
        pc_en      = 1'b0;
        state_d    = S_INT;
        irq_pend_d = 1'b0;
      end else if (bus.stall_in) begin
        bubble = 1'b1;
        fd_en  = 1'b0;
        pc_en  = 1'b0;
      end else if (bus.opcode == OP_CALL || bus.opcode == OP_RET || bus.opcode == OP_RETI) begin
        bubble = 1'b1;
        fd_en  = 1'b0;
        pc_en  = 1'b0;
        case (bus.opcode)
          OP_CALL: state_d = S_CALL;
          OP_RET:  state_d = S_RET;
          default: state_d = S_RETI;
        endcase
      end
    end else if (bus.stall_in) begin
      bubble = 1'b1;
      fd_en  = 1'b0;
      pc_en  = 1'b0;
    end else begin
      seq_mem = ((state_q == S_INT || state_q == S_CALL) ? MC_PUSH : MC_POP)
              | (flag_step ? MC_FLAG : 7'h00);
      if (step_q == last_idx) begin
        flush_out = 1'b1;
        state_d   = S_IDLE;
        step_d    = '0;
        case (state_q)
          S_INT:   jump_sel = 2'b10;
          S_CALL:  jump_sel = 2'b11;
          default: jump_sel = 2'b01;
        endcase
      end else begin
        fd_en  = 1'b0;
        pc_en  = 1'b0;
        step_d = step_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      irq_pend_q <= 1'b0;
      sp_q       <= SP_INIT;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      irq_pend_q <= irq_pend_d;
      if (bus.wb_en) rf_q[bus.wb_addr] <= bus.wb_data;
      if (bus.sp_we) sp_q <= bus.sp_wdata;
    end
  end

`ifdef DECODE_RF_BYPASS_EN
  assign bus.rsrc = (bus.wb_en && bus.wb_addr == bus.src) ? bus.wb_data : rf_q[bus.src];
  assign bus.rdst = (bus.wb_en && bus.wb_addr == bus.dst) ? bus.wb_data : rf_q[bus.dst];
`else
  assign bus.rsrc = rf_q[bus.src];
  assign bus.rdst = rf_q[bus.dst];
`endif

  assign bus.sp           = sp_q;
  assign bus.ex_ctl       = (bubble || state_q != S_IDLE) ? 14'h0 : dec_ex;
  assign bus.mem_ctl      = bubble ? 7'h0 : ((state_q == S_IDLE) ? dec_mem : seq_mem);
  assign bus.wb_ctl       = (bubble || state_q != S_IDLE) ? 6'h0 : dec_wb;
  assign bus.fd_en        = fd_en;
  assign bus.pc_en        = pc_en;
  assign bus.jump_sel     = jump_sel;
  assign bus.flush_out    = flush_out;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_step     = step_q;
  assign bus.dbg_irq_pend = irq_pend_q;
endmodule

// File: tb/tb_decode_seq_stage.sv
// Bench for decode_seq_stage: decode vector table, hand-built sequencer corner cases and a
// randomized run against a micro-op queue model of the stage.
module tb_decode_seq_stage;
  localparam int W = 16;
  localparam int NREG = 8;
  localparam int AW = 3;
  localparam int SPW = 32;
  localparam int PCW = 2;
  localparam logic [SPW-1:0] SP_RST = 32'h0000_0FFE;
  localparam logic [6:0] PUSHPC = 7'h05, POPPC = 7'h0A, PUSHF = 7'h15, POPF = 7'h1A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_seq_if #(.W(W), .NREG(NREG), .SPW(SPW)) bus();

  decode_seq_stage #(.W(W), .NREG(NREG), .SPW(SPW), .SP_INIT(SP_RST), .PC_WORDS(PCW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed { logic last; logic [1:0] js; logic [6:0] mem; } uop_t;
  typedef struct packed {
    logic [13:0] ex; logic [6:0] mem; logic [5:0] wb;
    logic fd; logic pc; logic [1:0] js; logic fo; logic busy;
  } outs_t;
  typedef struct {
    logic [5:0] op; logic stall; logic flush;
    logic [13:0] ex; logic [6:0] mem; logic [5:0] wb;
    logic fd; logic pc; logic fo;
  } vec_t;

  vec_t vecs[12];
  uop_t uop_q[$];
  logic [W-1:0] exp_q[$];
  int seq_len;
  logic m_pend;
  logic [W-1:0] m_rf[NREG];
  logic [SPW-1:0] m_sp;
  int n_checks = 0, n_errors = 0;
  int obs_busy, obs_wr;
  logic [7:0] js_log;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_seq(input logic [5:0] op);
    return (op == 6'h30 || op == 6'h31 || op == 6'h32);
  endfunction

  // Static decode expectations are the unstalled, unflushed rows of the vector table.
  function automatic logic [26:0] dec_lookup(input logic [5:0] op);
    for (int i = 0; i < 12; i++)
      if (vecs[i].op == op && !vecs[i].stall && !vecs[i].flush)
        return {vecs[i].ex, vecs[i].mem, vecs[i].wb};
    return '0;
  endfunction

  function automatic logic [W-1:0] rd_model(input logic [AW-1:0] a);
`ifdef DECODE_RF_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
`endif
    return m_rf[a];
  endfunction

  // kind: 0 interrupt entry, 1 CALL, 2 RET, 3 RETI
  task automatic load_seq(input int kind);
    uop_t u;
    if (kind == 3) uop_q.push_back('{1'b0, 2'b00, POPF});
    for (int i = 0; i < PCW; i++) uop_q.push_back('{1'b0, 2'b00, (kind <= 1) ? PUSHPC : POPPC});
    if (kind == 0) uop_q.push_back('{1'b0, 2'b00, PUSHF});
    u = uop_q.pop_back();
    u.last = 1'b1;
    u.js = (kind == 0) ? 2'b10 : (kind == 1) ? 2'b11 : 2'b01;
    uop_q.push_back(u);
    seq_len = uop_q.size();
  endtask

  function automatic outs_t model_out();
    outs_t o;
    uop_t u;
    o = '0;
    o.fd = 1'b1;
    o.pc = 1'b1;
    o.busy = (uop_q.size() != 0);
    if (bus.flush_in) o.fo = 1'b1;
    else if (!o.busy) begin
      if (bus.irq || m_pend || bus.stall_in || is_seq(bus.opcode)) begin o.fd = 1'b0; o.pc = 1'b0; end
      else {o.ex, o.mem, o.wb} = dec_lookup(bus.opcode);
    end else if (bus.stall_in) begin
      o.fd = 1'b0; o.pc = 1'b0;
    end else begin
      u = uop_q[0];
      o.mem = u.mem;
      if (u.last) begin o.js = u.js; o.fo = 1'b1; end
      else begin o.fd = 1'b0; o.pc = 1'b0; end
    end
    return o;
  endfunction

  task automatic model_commit();
    logic idle;
    idle = (uop_q.size() == 0);
    if (!rst) begin
      uop_q.delete();
      m_pend = 1'b0;
      m_sp = SP_RST;
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    end else begin
      if (bus.flush_in) begin
        uop_q.delete();
        m_pend = m_pend | bus.irq;
      end else if (idle) begin
        if (bus.irq || m_pend) begin load_seq(0); m_pend = 1'b0; end
        else if (!bus.stall_in && is_seq(bus.opcode)) load_seq(int'(bus.opcode) - 48 + 1);
      end else begin
        if (bus.irq) m_pend = 1'b1;
        if (!bus.stall_in) void'(uop_q.pop_front());
      end
      if (bus.wb_en) m_rf[bus.wb_addr] = bus.wb_data;
      if (bus.sp_we) m_sp = bus.sp_wdata;
    end
  endtask

  task automatic compare();
    outs_t e;
    e = model_out();
    check("ctl", {bus.ex_ctl, bus.mem_ctl, bus.wb_ctl}, {e.ex, e.mem, e.wb});
    check("fetch", {bus.fd_en, bus.pc_en, bus.jump_sel, bus.flush_out}, {e.fd, e.pc, e.js, e.fo});
    check("busy", bus.busy, e.busy);
    check("step", bus.dbg_step, e.busy ? 64'(seq_len - uop_q.size()) : 64'd0);
    check("irq_pend", bus.dbg_irq_pend, m_pend);
    check("rsrc", bus.rsrc, rd_model(bus.src));
    check("rdst", bus.rdst, rd_model(bus.dst));
    check("sp", bus.sp, m_sp);
    if (bus.busy) obs_busy++;
    if (bus.mem_ctl[0]) obs_wr++;
    if (bus.busy && bus.flush_out && !bus.flush_in) js_log = {js_log[5:0], bus.jump_sel};
  endtask

  task automatic step_cycle(input bit chk);
    @(negedge clk);
    if (chk) compare();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.opcode = 6'h00; bus.src = '0; bus.dst = '0; bus.irq = 1'b0;
    bus.stall_in = 1'b0; bus.flush_in = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0;
    bus.wb_data = '0; bus.sp_we = 1'b0; bus.sp_wdata = '0;
  endtask

  task automatic clr_obs();
    obs_busy = 0; obs_wr = 0; js_log = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SPW-1:0] spv;
    vecs[0]  = '{6'h00, 1'b0, 1'b0, 14'h0000, 7'h00, 6'h00, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{6'h01, 1'b0, 1'b0, 14'h0001, 7'h00, 6'h01, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{6'h02, 1'b0, 1'b0, 14'h0002, 7'h00, 6'h01, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{6'h03, 1'b0, 1'b0, 14'h0100, 7'h02, 6'h03, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{6'h04, 1'b0, 1'b0, 14'h0100, 7'h01, 6'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{6'h05, 1'b0, 1'b0, 14'h0000, 7'h05, 6'h00, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{6'h06, 1'b0, 1'b0, 14'h0000, 7'h0A, 6'h03, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{6'h07, 1'b0, 1'b0, 14'h2000, 7'h00, 6'h00, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{6'h3F, 1'b0, 1'b0, 14'h0000, 7'h00, 6'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{6'h01, 1'b1, 1'b0, 14'h0000, 7'h00, 6'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'h03, 1'b0, 1'b1, 14'h0000, 7'h00, 6'h00, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{6'h30, 1'b0, 1'b1, 14'h0000, 7'h00, 6'h00, 1'b1, 1'b1, 1'b1};
    clr_obs();
    seq_len = 0;
    m_pend = 1'b0;
    m_sp = SP_RST;
    rst = 1'b0;
    idle_in();
    step_cycle(0);
    step_cycle(0);
    check("rst_sp", bus.sp, 32'h0000_0FFE);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ctl", {bus.ex_ctl, bus.mem_ctl, bus.wb_ctl}, 27'h0);
    check("rst_fetch", {bus.fd_en, bus.pc_en, bus.jump_sel, bus.flush_out}, 5'b11000);
    check("rst_rsrc", bus.rsrc, 16'h0000);
    check("rst_step", {bus.dbg_step, bus.dbg_irq_pend}, 3'b000);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.opcode = vecs[i].op; bus.stall_in = vecs[i].stall; bus.flush_in = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_ctl", i), {bus.ex_ctl, bus.mem_ctl, bus.wb_ctl},
            {vecs[i].ex, vecs[i].mem, vecs[i].wb});
      check($sformatf("vec%0d_fetch", i), {bus.fd_en, bus.pc_en, bus.flush_out},
            {vecs[i].fd, vecs[i].pc, vecs[i].fo});
      step_cycle(1);
    end
    idle_in();

    // CALL: two pushes, target on the last cycle
    clr_obs();
    bus.opcode = 6'h30; step_cycle(1);
    bus.opcode = 6'h00; repeat (4) step_cycle(1);
    check("call_busy_cycles", obs_busy, PCW);
    check("call_pushes", obs_wr, PCW);
    check("call_js", js_log[1:0], 2'b11);

    // irq at RET step 0: RET completes, interrupt entry follows
    clr_obs();
    bus.opcode = 6'h31; step_cycle(1);
    bus.opcode = 6'h00; bus.irq = 1'b1; step_cycle(1);
    bus.irq = 1'b0; step_cycle(1);
    step_cycle(1);
    #1;
    check("int_start", {bus.busy, bus.mem_ctl}, {1'b1, PUSHPC});
    repeat (4) step_cycle(1);
    check("ret_int_busy", obs_busy, 5);
    check("ret_int_js", js_log[3:0], 4'b0110);

    // RETI stalled at step 1 for two cycles
    clr_obs();
    bus.opcode = 6'h32; step_cycle(1);
    bus.opcode = 6'h00; step_cycle(1);
    bus.stall_in = 1'b1; step_cycle(1);
    #1;
    check("reti_stall_step", bus.dbg_step, 2'd1);
    check("reti_stall_ctl", {bus.ex_ctl, bus.mem_ctl, bus.wb_ctl}, 27'h0);
    step_cycle(1);
    bus.stall_in = 1'b0; repeat (3) step_cycle(1);
    check("reti_busy", obs_busy, 5);
    check("reti_js", js_log[1:0], 2'b01);

    // flush at CALL step 0
    clr_obs();
    bus.opcode = 6'h30; step_cycle(1);
    bus.opcode = 6'h00; bus.flush_in = 1'b1;
    #1;
    check("flush_out", {bus.flush_out, bus.mem_ctl}, {1'b1, 7'h00});
    step_cycle(1);
    bus.flush_in = 1'b0;
    #1;
    check("flush_idle", bus.busy, 1'b0);
    repeat (2) step_cycle(1);
    check("flush_pushes", obs_wr, 0);

    // reset mid interrupt entry
    bus.irq = 1'b1; step_cycle(1);
    bus.irq = 1'b0; step_cycle(1);
    rst = 1'b0; step_cycle(1);
    rst = 1'b1;
    clr_obs();
    #1;
    check("rst_mid_busy", bus.busy, 1'b0);
    repeat (2) step_cycle(1);
    check("rst_mid_pushes", obs_wr, 0);

    // write-back to read visibility
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h1234; step_cycle(1);
    bus.wb_data = 16'hBEEF; bus.src = 3'd3;
`ifdef DECODE_RF_BYPASS_EN
    exp_q.push_back(16'hBEEF);
`else
    exp_q.push_back(16'h1234);
`endif
    exp_q.push_back(16'hBEEF);
    #1;
    check("byp_same", bus.rsrc, exp_q.pop_front());
    step_cycle(1);
    bus.wb_en = 1'b0;
    #1;
    check("byp_next", bus.rsrc, exp_q.pop_front());

    // SP load visible next cycle
    spv = $urandom;
    bus.sp_we = 1'b1; bus.sp_wdata = spv; step_cycle(1);
    bus.sp_we = 1'b0;
    #1;
    check("sp_load", bus.sp, spv);
    idle_in();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 15) bus.opcode = 6'(48 + $urandom_range(0, 2));
      else bus.opcode = 6'($urandom_range(0, 8));
      bus.irq      = ($urandom_range(0, 99) < 4);
      bus.stall_in = ($urandom_range(0, 99) < 10);
      bus.flush_in = ($urandom_range(0, 99) < 5);
      bus.wb_en    = 1'($urandom_range(0, 1));
      bus.wb_addr  = AW'($urandom_range(0, NREG - 1));
      bus.wb_data  = W'($urandom);
      bus.src      = AW'($urandom_range(0, NREG - 1));
      bus.dst      = AW'($urandom_range(0, NREG - 1));
      bus.sp_we    = ($urandom_range(0, 99) < 5);
      bus.sp_wdata = $urandom;
      rst          = ($urandom_range(0, 99) != 0);
      step_cycle(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
